// File: rtl/kbd_mouse_pkg.sv
// Shared constants and FSM state type for the keyboard/mouse byte receiver.
package kbd_mouse_pkg;

    localparam logic [1:0] KMT_MOUSE_X = 2'd0;
    localparam logic [1:0] KMT_MOUSE_Y = 2'd1;
    localparam logic [1:0] KMT_KEY     = 2'd2;
    localparam logic [1:0] KMT_OSD     = 2'd3;

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_CAPTURE  = 2'd1,
        S_DISPATCH = 2'd2
    } kmr_state_t;

    // Two's-complement delta added to a wrapping 8-bit position counter.
    function automatic logic [7:0] wrap_add(input logic [7:0] pos, input logic [7:0] delta);
        return pos + delta;
    endfunction

endpackage

// File: rtl/kmr_fifo.sv
// Small synchronous keycode FIFO; a push into a full FIFO is dropped unless a pop frees a slot in the same cycle.
module kmr_fifo #(
    parameter int FIFO_AW = 3
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       push,
    input  logic [7:0] wdata,
    input  logic       pop,
    output logic [7:0] rdata,
    output logic       empty,
    output logic       dropped
);

    localparam int DEPTH = 1 << FIFO_AW;

    logic [7:0]         mem [DEPTH];
    logic [FIFO_AW-1:0] wr_ptr_reg;
    logic [FIFO_AW-1:0] rd_ptr_reg;
    logic [FIFO_AW:0]   count_reg;
    logic               full;
    logic               do_push;
    logic               do_pop;

    assign empty   = (count_reg == '0);
    assign full    = (count_reg == (FIFO_AW+1)'(DEPTH));
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign dropped = push && full && !do_pop;

    // Head is forced to zero while empty so the output has a defined reset value.
    assign rdata = empty ? 8'h00 : mem[rd_ptr_reg];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr_reg] <= wdata;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            end
            if (do_pop) begin
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count_reg <= count_reg + (FIFO_AW+1)'(1);
                2'b01:   count_reg <= count_reg - (FIFO_AW+1)'(1);
                default: count_reg <= count_reg;
            endcase
        end
    end

endmodule

// File: rtl/kbd_mouse_rx.sv
// Carries SPI-domain keyboard/mouse bytes into CLK: mouse counters, keycode FIFO, OSD strobes.
// Optional KMR_OVF_FLAG_EN adds a sticky KEY_OVF output for dropped keycodes.
module kbd_mouse_rx
    import kbd_mouse_pkg::*;
#(
    parameter int FIFO_AW     = 3,
    parameter int SYNC_STAGES = 2
) (
    input  logic       CLK,
    input  logic       RESET_N,
    input  logic       KMS_LEVEL,
    input  logic [1:0] KBD_MOUSE_TYPE,
    input  logic [7:0] KBD_MOUSE_DATA,
    input  logic [2:0] MOUSE_BUTTONS,
    output logic [7:0] MOUSE_X,
    output logic [7:0] MOUSE_Y,
    output logic [2:0] MOUSE_BTN,
    output logic       KEY_VALID,
    output logic [7:0] KEY_DATA,
    input  logic       KEY_POP,
`ifdef KMR_OVF_FLAG_EN
    output logic       KEY_OVF,
`endif
    output logic       OSD_STROBE,
    output logic [7:0] OSD_CODE
);

    logic       kms_sync_reg [SYNC_STAGES];
    logic [2:0] btn_sync_reg [SYNC_STAGES];
    logic       hist_reg;
    logic       kms_event;

    kmr_state_t state_reg;
    kmr_state_t state_next;
    logic       take_event;
    logic       capture;
    logic       dispatch;

    logic [1:0] type_reg;
    logic [7:0] data_reg;
    logic [7:0] mouse_x_reg;
    logic [7:0] mouse_y_reg;
    logic       osd_strobe_reg;
    logic [7:0] osd_code_reg;
    logic       key_push;
    logic       key_empty;

    genvar gi;
    generate
        for (gi = 0; gi < SYNC_STAGES; gi++) begin : g_sync
            if (gi == 0) begin : g_first
                always_ff @(posedge CLK or negedge RESET_N) begin
                    if (!RESET_N) begin
                        kms_sync_reg[gi] <= 1'b0;
                        btn_sync_reg[gi] <= 3'b000;
                    end else begin
                        kms_sync_reg[gi] <= KMS_LEVEL;
                        btn_sync_reg[gi] <= MOUSE_BUTTONS;
                    end
                end
            end else begin : g_rest
                always_ff @(posedge CLK or negedge RESET_N) begin
                    if (!RESET_N) begin
                        kms_sync_reg[gi] <= 1'b0;
                        btn_sync_reg[gi] <= 3'b000;
                    end else begin
                        kms_sync_reg[gi] <= kms_sync_reg[gi-1];
                        btn_sync_reg[gi] <= btn_sync_reg[gi-1];
                    end
                end
            end
        end
    endgenerate

    // History only advances when the event is accepted, so an edge seen while busy stays pending.
    assign kms_event = (kms_sync_reg[SYNC_STAGES-1] != hist_reg);

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state_reg <= S_IDLE;
            hist_reg  <= 1'b0;
        end else begin
            state_reg <= state_next;
            if (take_event) begin
                hist_reg <= kms_sync_reg[SYNC_STAGES-1];
            end
        end
    end

    always_comb begin
        state_next = state_reg;
        take_event = 1'b0;
        capture    = 1'b0;
        dispatch   = 1'b0;
        case (state_reg)
            S_IDLE: begin
                if (kms_event) begin
                    take_event = 1'b1;
                    state_next = S_CAPTURE;
                end
            end
            S_CAPTURE: begin
                capture    = 1'b1;
                state_next = S_DISPATCH;
            end
            S_DISPATCH: begin
                dispatch   = 1'b1;
                state_next = S_IDLE;
            end
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            type_reg       <= 2'b00;
            data_reg       <= 8'h00;
            mouse_x_reg    <= 8'h00;
            mouse_y_reg    <= 8'h00;
            osd_strobe_reg <= 1'b0;
            osd_code_reg   <= 8'h00;
        end else begin
            osd_strobe_reg <= dispatch && (type_reg == KMT_OSD);
            if (capture) begin
                type_reg <= KBD_MOUSE_TYPE;
                data_reg <= KBD_MOUSE_DATA;
            end
            if (dispatch) begin
                case (type_reg)
                    KMT_MOUSE_X: mouse_x_reg  <= wrap_add(mouse_x_reg, data_reg);
                    KMT_MOUSE_Y: mouse_y_reg  <= wrap_add(mouse_y_reg, data_reg);
                    KMT_OSD:     osd_code_reg <= data_reg;
                    default:     ;
                endcase
            end
        end
    end

    assign key_push = dispatch && (type_reg == KMT_KEY);

`ifdef KMR_OVF_FLAG_EN
    logic key_dropped;
    logic key_ovf_reg;

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            key_ovf_reg <= 1'b0;
        end else if (key_dropped) begin
            key_ovf_reg <= 1'b1;
        end
    end

    assign KEY_OVF = key_ovf_reg;
`endif

    kmr_fifo #(
        .FIFO_AW (FIFO_AW)
    ) u_fifo (
        .clk     (CLK),
        .rst_n   (RESET_N),
        .push    (key_push),
        .wdata   (data_reg),
        .pop     (KEY_POP),
        .rdata   (KEY_DATA),
        .empty   (key_empty),
`ifdef KMR_OVF_FLAG_EN
        .dropped (key_dropped)
`else
        .dropped ()
`endif
    );

    assign KEY_VALID  = !key_empty;
    assign MOUSE_X    = mouse_x_reg;
    assign MOUSE_Y    = mouse_y_reg;
    assign MOUSE_BTN  = btn_sync_reg[SYNC_STAGES-1];
    assign OSD_STROBE = osd_strobe_reg;
    assign OSD_CODE   = osd_code_reg;

endmodule

// File: tb/tb_kbd_mouse_rx.sv
// Scoreboard bench for kbd_mouse_rx: stimulus pushes expected results, a negedge monitor pops and compares.
module tb_kbd_mouse_rx;

    localparam int DEPTH = 8;

    logic       CLK = 1'b0;
    logic       RESET_N;
    logic       KMS_LEVEL;
    logic [1:0] KBD_MOUSE_TYPE;
    logic [7:0] KBD_MOUSE_DATA;
    logic [2:0] MOUSE_BUTTONS;
    logic [7:0] MOUSE_X;
    logic [7:0] MOUSE_Y;
    logic [2:0] MOUSE_BTN;
    logic       KEY_VALID;
    logic [7:0] KEY_DATA;
    logic       KEY_POP;
    logic       OSD_STROBE;
    logic [7:0] OSD_CODE;
`ifdef KMR_OVF_FLAG_EN
    logic       KEY_OVF;
`endif

    kbd_mouse_rx #(.FIFO_AW(3), .SYNC_STAGES(2)) dut (
        .CLK            (CLK),
        .RESET_N        (RESET_N),
        .KMS_LEVEL      (KMS_LEVEL),
        .KBD_MOUSE_TYPE (KBD_MOUSE_TYPE),
        .KBD_MOUSE_DATA (KBD_MOUSE_DATA),
        .MOUSE_BUTTONS  (MOUSE_BUTTONS),
        .MOUSE_X        (MOUSE_X),
        .MOUSE_Y        (MOUSE_Y),
        .MOUSE_BTN      (MOUSE_BTN),
        .KEY_VALID      (KEY_VALID),
        .KEY_DATA       (KEY_DATA),
        .KEY_POP        (KEY_POP),
`ifdef KMR_OVF_FLAG_EN
        .KEY_OVF        (KEY_OVF),
`endif
        .OSD_STROBE     (OSD_STROBE),
        .OSD_CODE       (OSD_CODE)
    );

    always #5 CLK = ~CLK;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model state
    logic [7:0] exp_x [$];
    logic [7:0] exp_y [$];
    logic [7:0] exp_key [$];
    logic [7:0] exp_osd [$];
    int         model_x = 0;
    int         model_y = 0;
    bit         model_ovf = 1'b0;
    int         osd_sent = 0;
    int         strobe_count = 0;
    logic       kms = 1'b0;
    logic [7:0] prev_x = 8'h00;
    logic [7:0] prev_y = 8'h00;

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic unexpected(input string name, input logic [7:0] act);
        n_checks++;
        n_errors++;
        $display("FAIL %s: got %h with nothing expected", name, act);
    endtask

    function automatic int wrap8(input int pos, input logic [7:0] delta);
        int s;
        s = pos + int'($signed(delta));
        return ((s % 256) + 256) % 256;
    endfunction

    // Monitor: compares every observable DUT response against the scoreboard queues.
    always @(negedge CLK) begin
        if (!RESET_N) begin
            prev_x = MOUSE_X;
            prev_y = MOUSE_Y;
        end else begin
            if (MOUSE_X !== prev_x) begin
                if (exp_x.size() == 0) unexpected("mouse_x", MOUSE_X);
                else check("mouse_x", MOUSE_X, exp_x.pop_front());
                prev_x = MOUSE_X;
            end
            if (MOUSE_Y !== prev_y) begin
                if (exp_y.size() == 0) unexpected("mouse_y", MOUSE_Y);
                else check("mouse_y", MOUSE_Y, exp_y.pop_front());
                prev_y = MOUSE_Y;
            end
            if (OSD_STROBE === 1'b1) begin
                strobe_count++;
                if (exp_osd.size() == 0) unexpected("osd_strobe", OSD_CODE);
                else check("osd_code", OSD_CODE, exp_osd.pop_front());
            end
            if (KEY_POP === 1'b1 && KEY_VALID === 1'b1) begin
                if (exp_key.size() == 0) unexpected("key_pop", KEY_DATA);
                else check("key_data", KEY_DATA, exp_key.pop_front());
            end
        end
    end

    // One byte from the SPI side; the model is updated from the byte's meaning, not DUT timing.
    task automatic send(input logic [1:0] t, input logic [7:0] d, input bit pop_with);
        @(posedge CLK); #1;
        KBD_MOUSE_TYPE = t;
        KBD_MOUSE_DATA = d;
        kms = ~kms;
        KMS_LEVEL = kms;
        $display("send type %0d data %h pop %0d", t, d, pop_with);
        case (t)
            2'd0: begin
                model_x = wrap8(model_x, d);
                if (d != 8'h00) exp_x.push_back(8'(model_x));
            end
            2'd1: begin
                model_y = wrap8(model_y, d);
                if (d != 8'h00) exp_y.push_back(8'(model_y));
            end
            2'd2: begin
                if (exp_key.size() < DEPTH || pop_with) exp_key.push_back(d);
                else model_ovf = 1'b1;
            end
            default: begin
                exp_osd.push_back(d);
                osd_sent++;
            end
        endcase
        if (pop_with) begin
            repeat (4) @(posedge CLK);
            #1 KEY_POP = 1'b1;
            @(posedge CLK); #1 KEY_POP = 1'b0;
        end
        repeat (8) @(posedge CLK);
    endtask

    task automatic pop_pulse();
        @(posedge CLK); #1 KEY_POP = 1'b1;
        @(posedge CLK); #1 KEY_POP = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < 20 && KEY_VALID === 1'b1; i++) pop_pulse();
        @(posedge CLK); #1;
        check("drain_empty", {7'd0, KEY_VALID}, 8'h00);
    endtask

    task automatic model_reset();
        exp_x.delete();
        exp_y.delete();
        exp_key.delete();
        exp_osd.delete();
        model_x = 0;
        model_y = 0;
        model_ovf = 1'b0;
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_x"}, MOUSE_X, 8'h00);
        check({tag, "_y"}, MOUSE_Y, 8'h00);
        check({tag, "_btn"}, {5'd0, MOUSE_BTN}, 8'h00);
        check({tag, "_key_valid"}, {7'd0, KEY_VALID}, 8'h00);
        check({tag, "_key_data"}, KEY_DATA, 8'h00);
        check({tag, "_osd_strobe"}, {7'd0, OSD_STROBE}, 8'h00);
        check({tag, "_osd_code"}, OSD_CODE, 8'h00);
`ifdef KMR_OVF_FLAG_EN
        check({tag, "_ovf"}, {7'd0, KEY_OVF}, 8'h00);
`endif
    endtask

    initial begin
        logic [2:0] b_old;
        logic [2:0] b_new;
        logic [7:0] x_snap;
        logic [7:0] y_snap;
        int         s_snap;

        RESET_N = 1'b0;
        KMS_LEVEL = 1'b0;
        KBD_MOUSE_TYPE = 2'd0;
        KBD_MOUSE_DATA = 8'h00;
        MOUSE_BUTTONS = 3'b000;
        KEY_POP = 1'b0;
        repeat (3) @(posedge CLK);
        #1;
        check_reset_values("reset");
        RESET_N = 1'b1;
        repeat (3) @(posedge CLK);

        // Mouse X accumulation with a negative delta
        send(2'd0, 8'h05, 1'b0);
        check("x_after_05", MOUSE_X, 8'h05);
        send(2'd0, 8'hFE, 1'b0);
        check("x_after_fe", MOUSE_X, 8'h03);

        // Mouse Y wrap through 0xFF
        send(2'd1, 8'hFF, 1'b0);
        check("y_at_ff", MOUSE_Y, 8'hFF);
        send(2'd1, 8'h02, 1'b0);
        check("y_wrap", MOUSE_Y, 8'h01);

        // Overfill the FIFO: ninth keycode is dropped
        for (int i = 0; i < 9; i++) send(2'd2, 8'(8'h10 + i), 1'b0);
        check("fifo_full_valid", {7'd0, KEY_VALID}, 8'h01);
        check("fifo_full_head", KEY_DATA, 8'h10);
`ifdef KMR_OVF_FLAG_EN
        check("key_ovf_set", {7'd0, KEY_OVF}, 8'h01);
`endif

        // Push and pop together while full
        send(2'd2, 8'h40, 1'b1);
        check("simul_head", KEY_DATA, 8'h11);

        // OSD keycode leaves mouse and FIFO alone
        x_snap = MOUSE_X;
        y_snap = MOUSE_Y;
        s_snap = strobe_count;
        send(2'd3, 8'h45, 1'b0);
        check("osd_code_hold", OSD_CODE, 8'h45);
        check("osd_one_strobe", 8'(strobe_count - s_snap), 8'h01);
        check("osd_x_unchanged", MOUSE_X, x_snap);
        check("osd_y_unchanged", MOUSE_Y, y_snap);
        check("osd_fifo_head", KEY_DATA, 8'h11);

        drain();

        // Button synchroniser depth
        for (int i = 0; i < 6; i++) begin
            @(posedge CLK); #1;
            b_old = MOUSE_BUTTONS;
            b_new = 3'($urandom_range(0, 7));
            MOUSE_BUTTONS = b_new;
            @(negedge CLK);
            @(posedge CLK);
            @(negedge CLK);
            check("btn_still_old", {5'd0, MOUSE_BTN}, {5'd0, b_old});
            @(posedge CLK);
            @(negedge CLK);
            check("btn_new", {5'd0, MOUSE_BTN}, {5'd0, b_new});
        end

        // Randomised traffic with occasional pops
        for (int i = 0; i < 80; i++) begin
            send(2'($urandom_range(0, 3)), 8'($urandom_range(0, 255)), 1'b0);
            if ($urandom_range(0, 2) == 0) pop_pulse();
        end
`ifdef KMR_OVF_FLAG_EN
        check("key_ovf_model", {7'd0, KEY_OVF}, {7'd0, model_ovf});
`endif
        drain();
        check("random_x_final", MOUSE_X, 8'(model_x));
        check("random_y_final", MOUSE_Y, 8'(model_y));

        // Reset while the FSM is capturing a keycode
        @(posedge CLK); #1;
        KBD_MOUSE_TYPE = 2'd2;
        KBD_MOUSE_DATA = 8'h77;
        kms = ~kms;
        KMS_LEVEL = kms;
        repeat (3) @(posedge CLK);
        #1;
        RESET_N = 1'b0;
        kms = 1'b0;
        KMS_LEVEL = 1'b0;
        MOUSE_BUTTONS = 3'b000;
        model_reset();
        #1;
        check_reset_values("midreset");
        repeat (2) @(posedge CLK);
        #1 RESET_N = 1'b1;
        repeat (10) @(posedge CLK);
        #1;
        check("midreset_no_push", {7'd0, KEY_VALID}, 8'h00);
        check("midreset_x", MOUSE_X, 8'h00);

        // Block still works after reset
        send(2'd2, 8'h55, 1'b0);
        check("post_reset_key", KEY_DATA, 8'h55);
        drain();

        check("left_x", 8'(exp_x.size()), 8'h00);
        check("left_y", 8'(exp_y.size()), 8'h00);
        check("left_key", 8'(exp_key.size()), 8'h00);
        check("left_osd", 8'(exp_osd.size()), 8'h00);
        check("strobe_total", 8'(strobe_count), 8'(osd_sent));

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/kbd_mouse_rx.md
# kbd_mouse_rx

Receives keyboard/mouse bytes that the SPI user-IO stage delivers in the SPI clock domain, and carries them safely into the system clock domain. The block accumulates mouse deltas into Amiga-style 8-bit X/Y position counters, synchronises the mouse buttons, queues Amiga keycodes in a small FIFO for the keyboard serialiser, and emits OSD keycodes as single-cycle strobes. It sits directly downstream of the user-IO SPI receiver and upstream of the CIA keyboard and JOY0DAT logic.

## Interface
Parameters:
- FIFO_AW, 3: keycode FIFO address width; depth = 2**FIFO_AW.
- SYNC_STAGES, 2: synchroniser flops on KMS_LEVEL and MOUSE_BUTTONS; legal range 2–3.

Ports:
- CLK  in  1  system clock; the only clock in the block.
- RESET_N  in  1  asynchronous, active-low reset.
- KMS_LEVEL  in  1  toggles once per received byte; asynchronous to CLK.
- KBD_MOUSE_TYPE  in  2  0 = mouse X, 1 = mouse Y, 2 = keycode, 3 = OSD keycode; held stable while KMS_LEVEL is in flight.
- KBD_MOUSE_DATA  in  8  payload; held stable like KBD_MOUSE_TYPE.
- MOUSE_BUTTONS  in  3  raw button levels; asynchronous.
- MOUSE_X  out  8  X position counter; wraps modulo 256.
- MOUSE_Y  out  8  Y position counter; wraps modulo 256.
- MOUSE_BTN  out  3  synchronised MOUSE_BUTTONS.
- KEY_VALID  out  1  FIFO is not empty.
- KEY_DATA  out  8  FIFO head; valid while KEY_VALID = 1.
- KEY_POP  in  1  consumer pop; ignored when KEY_VALID = 0.
- OSD_STROBE  out  1  one-cycle pulse per OSD keycode.
- OSD_CODE  out  8  last OSD keycode; holds its value between strobes.

## Operation
- Event detect: KMS_LEVEL passes through SYNC_STAGES flops plus one history flop. An event is raised when the synchronised value differs from the history flop.
- FSM states:
  - S_IDLE: on an event, go to S_CAPTURE.
  - S_CAPTURE: register KBD_MOUSE_TYPE and KBD_MOUSE_DATA into hold registers; go to S_DISPATCH.
  - S_DISPATCH: act on the held type (below); return to S_IDLE.
- Dispatch actions:
  - Type 0: MOUSE_X <= MOUSE_X + data, with data treated as 8-bit two's complement and the sum wrapping.
  - Type 1: MOUSE_Y <= MOUSE_Y + data, same rule.
  - Type 2: push data into the FIFO.
  - Type 3: OSD_CODE <= data and OSD_STROBE = 1 for exactly this one cycle.
- An event that arrives while the FSM is outside S_IDLE stays pending in the history comparison and is serviced on the next return to S_IDLE. No events are lost if each SPI byte lasts at least 8 SPI clocks and f(CLK) ≥ f(SPI_CLK).
- FIFO rules:
  - Push when full with no pop in the same cycle: the byte is dropped and the FIFO contents are unchanged.
  - Push and pop in the same cycle when full: both take effect; occupancy stays full.
  - Pop when empty: no effect.
- MOUSE_BTN is MOUSE_BUTTONS delayed by SYNC_STAGES flops. No debouncing.
- Reset values:
  - MOUSE_X = MOUSE_Y = 0x00; MOUSE_BTN = 0.
  - FIFO empty; KEY_VALID = 0; KEY_DATA = 0x00.
  - OSD_STROBE = 0; OSD_CODE = 0x00; FSM in S_IDLE.
  - Synchroniser and history flops cleared to 0.
- Reset mid-operation: an in-flight event is discarded. If KMS_LEVEL = 1 when reset releases, one spurious event is seen after reset, because the history flop resets to 0. Firmware tolerates this since it resends state.

## Timing
- KMS_LEVEL edge to event detect: SYNC_STAGES+1 CLK edges.
- Event to S_CAPTURE: 1 cycle.
- S_CAPTURE to result: 1 cycle. MOUSE_X/Y, the FIFO push and OSD_STROBE become visible in the cycle after S_DISPATCH.
- Total latency from the synchronised edge: 3 cycles.
- FIFO push to KEY_VALID high: 1 cycle. KEY_POP advances KEY_DATA on the next cycle.
- Minimum spacing between serviced events: 3 cycles.

## Configuration
- KMR_OVF_FLAG_EN defined: adds output KEY_OVF (1 bit). It is a sticky flag set whenever a push is dropped, is cleared only by RESET_N, and its reset value is 0.
- KMR_OVF_FLAG_EN undefined: no KEY_OVF port. Dropped pushes are silent.

## Structure
- Package kbd_mouse_pkg holds:
  - KMT_MOUSE_X/KMT_MOUSE_Y/KMT_KEY/KMT_OSD 2-bit type constants.
  - The FSM state typedef (S_IDLE, S_CAPTURE, S_DISPATCH).
- Sub-module kmr_fifo: synchronous FIFO parameterised by FIFO_AW, with the push/pop/full/empty semantics above. Occupancy counter is FIFO_AW+1 bits wide.

## Test plan
- Reset, then toggle KMS_LEVEL with type 0 and data 0x05, then type 0 and data 0xFE -> MOUSE_X = 0x05, then 0x03.
- MOUSE_Y at 0xFF, type 1 with data 0x02 -> MOUSE_Y = 0x01 (wrap).
- Push 9 keycodes 0x10..0x18 with no pop -> FIFO holds 0x10..0x17; 0x18 is dropped; KEY_OVF = 1 when KMR_OVF_FLAG_EN is defined.
- FIFO full, then KEY_POP held in the same cycle as a push of 0x40 -> head goes 0x10 to 0x11; 0x40 is appended last.
- Type 3 with data 0x45 -> exactly one OSD_STROBE cycle; OSD_CODE = 0x45; MOUSE_X/Y and the FIFO are unchanged.
- Assert RESET_N low while the FSM is in S_CAPTURE -> all outputs return to their reset values; no FIFO push occurs.
